// File: rtl/askfsk_tx_core.sv
// ASK/FSK transmit core: MSB-first serializer, phase-continuous triangle DDS,
// per-bit modulation shaping and a glitch-free PWM output stage.
module askfsk_tx_core #(
    parameter int MSG_W   = 8,
    parameter int PHASE_W = 16,
    parameter int AMP_W   = 9,
    parameter int BAUD_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               send,
    input  logic [MSG_W-1:0]   msg,
    input  logic [1:0]         mode,
    input  logic [BAUD_W-1:0]  baud_div,
    input  logic [PHASE_W-1:0] fword_one,
    input  logic [PHASE_W-1:0] fword_zero,
    output logic               busy,
    output logic               done,
    output logic               ser_bit,
    output logic [AMP_W-1:0]   sample,
    output logic               pwm_out
);

    localparam int IDX_W = $clog2(MSG_W);

    typedef enum logic {IDLE, DATA} state_t;

    state_t             state;
    logic [MSG_W-1:0]   shreg;
    logic [BAUD_W-1:0]  baud_q;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] inc;
    logic [AMP_W-1:0]   t;
    logic [AMP_W-1:0]   tri_val;
    logic [AMP_W-1:0]   pwm_cnt;
    logic [AMP_W-1:0]   duty;

    // FSK only swaps the increment for 0 bits; every other mode runs on fword_one
    always_comb begin
        inc = fword_one;
        if (mode == 2'b01 && !ser_bit)
            inc = fword_zero;
    end

    always_comb begin
        t       = phase[PHASE_W-2 -: AMP_W];
        tri_val = phase[PHASE_W-1] ? ~t : t;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ser_bit  <= 1'b0;
            shreg    <= '0;
            baud_q   <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            phase    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (send) begin
                        state    <= DATA;
                        busy     <= 1'b1;
                        shreg    <= msg;
                        ser_bit  <= msg[MSG_W-1];
                        baud_q   <= baud_div;
                        baud_cnt <= '0;
                        bit_idx  <= IDX_W'(MSG_W - 1);
                        phase    <= '0;
                    end
                end
                DATA: begin
                    // phase runs straight through bit boundaries
                    phase <= phase + inc;
                    if (baud_cnt == baud_q) begin
                        baud_cnt <= '0;
                        if (bit_idx == '0) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            ser_bit <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx - IDX_W'(1);
                            shreg   <= shreg << 1;
                            ser_bit <= shreg[MSG_W-2];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample <= '0;
        end else if (!busy) begin
            sample <= '0;
        end else begin
            case (mode)
                2'b00:   sample <= ser_bit ? tri_val : '0;
                2'b10:   sample <= ser_bit ? tri_val : (tri_val >> 1);
                default: sample <= tri_val;
            endcase
        end
    end

    // duty reloads only at the period boundary so a period never changes shape
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + AMP_W'(1);
            if (&pwm_cnt)
                duty <= sample;
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: tb/tb_askfsk_tx_core.sv
// Directed bench for askfsk_tx_core: framing, triangle shaping, OOK/ASK,
// handshake, PWM duty and asynchronous abort.
module tb_askfsk_tx_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        send;
    logic [7:0]  msg;
    logic [1:0]  mode;
    logic [15:0] baud_div;
    logic [15:0] fword_one;
    logic [15:0] fword_zero;
    logic        busy;
    logic        done;
    logic        ser_bit;
    logic [8:0]  sample;
    logic        pwm_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] tri_tab [4] = '{9'd0, 9'd256, 9'd511, 9'd255};

    askfsk_tx_core dut (
        .clk(clk), .rst(rst), .send(send), .msg(msg), .mode(mode),
        .baud_div(baud_div), .fword_one(fword_one), .fword_zero(fword_zero),
        .busy(busy), .done(done), .ser_bit(ser_bit), .sample(sample),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        chk(tag, done, 1);
    endtask

    // 64-clock frame of msg 0F at fword 4000: bits 0 for the first 32 clocks
    task automatic run_shape(input logic [1:0] m, input string tag);
        logic [8:0] e;
        msg = 8'h0F; mode = m; baud_div = 16'd7; fword_one = 16'h4000; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            e = tri_tab[(k-1)%4];
            if (k <= 32) e = (m == 2'b00) ? 9'd0 : (e >> 1);
            chk(tag, sample, e);
        end
        chk({tag, "_done"}, done, 1);
        @(negedge clk);
        chk({tag, "_idle_sample"}, sample, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [7:0] m2;
        rst = 1'b0; send = 1'b0; msg = 8'h00; mode = 2'b00; baud_div = 16'd0;
        fword_one = 16'h0; fword_zero = 16'h0;

        // reset held while inputs wiggle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            send = ~send; msg = msg + 8'h37;
        end
        chk("rst_busy", busy, 0);
        chk("rst_outs", {done, ser_bit, sample, pwm_out}, 0);
        send = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rel_busy", busy, 0);
        chk("rel_outs", {done, ser_bit, sample, pwm_out}, 0);

        // FSK framing
        m2 = 8'hA5; msg = m2; mode = 2'b01; baud_div = 16'd3;
        fword_one = 16'h1234; fword_zero = 16'h0F0F; send = 1'b1;
        @(negedge clk);
        send = 1'b0; cnt = 0;
        for (int k = 0; k < 32; k++) begin
            chk("fsk_bit", ser_bit, m2[7 - k/4]);
            cnt += busy;
            @(negedge clk);
        end
        chk("fsk_busy_len", cnt, 32);
        chk("fsk_end_busy", busy, 0);
        chk("fsk_done", done, 1);
        chk("fsk_end_bit", ser_bit, 0);
        chk("fsk_phase", dut.phase, 16'h1430);
        @(negedge clk);
        chk("fsk_done_pulse", done, 0);

        // triangle values
        msg = 8'hFF; mode = 2'b01; baud_div = 16'd3; fword_one = 16'h4000; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("tri_sample", sample, tri_tab[(k-1)%4]);
        end
        wait_done("tri_done");
        @(negedge clk);

        run_shape(2'b00, "ook");
        run_shape(2'b10, "ask");

        // send pulse mid-frame ignored, baud_div 0
        msg = 8'h81; mode = 2'b11; baud_div = 16'd0; send = 1'b1;
        @(negedge clk);
        send = 1'b0; cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cnt += busy;
            if (k == 3) send = 1'b1;
            if (k == 4) send = 1'b0;
            @(negedge clk);
        end
        chk("hs_len", cnt, 8);
        chk("hs_done", done, 1);
        @(negedge clk);
        chk("hs_idle", busy, 0);

        // send held across done: one IDLE cycle, new msg latched
        msg = 8'h3C; send = 1'b1;
        @(negedge clk);
        chk("b2b_first_bit", ser_bit, 0);
        msg = 8'hC3;
        repeat (8) @(negedge clk);
        chk("b2b_gap_busy", busy, 0);
        chk("b2b_gap_done", done, 1);
        @(negedge clk);
        send = 1'b0;
        chk("b2b_restart", busy, 1);
        chk("b2b_bit7", ser_bit, 1);
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            chk("b2b_bits", ser_bit, m2_c3(j));
        end
        @(negedge clk);
        chk("b2b_done2", done, 1);
        @(negedge clk);

        // PWM at duty 256: freeze phase at 4000 by zeroing the increment
        msg = 8'hFF; mode = 2'b11; baud_div = 16'd1023; fword_one = 16'h4000; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        @(negedge clk);
        fword_one = 16'h0000;
        repeat (1100) @(negedge clk);
        chk("pwm_sample", sample, 256);
        cnt = 0;
        for (int i = 0; i < 512; i++) begin
            cnt += pwm_out;
            @(negedge clk);
        end
        chk("pwm_high", cnt, 256);

        // asynchronous abort mid-frame
        repeat (2048) @(negedge clk);
        chk("abort_pre_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_outs", {done, ser_bit, sample, pwm_out}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt += done + busy;
        end
        chk("abort_quiet", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    function automatic logic m2_c3(input int j);
        logic [7:0] v;
        v = 8'hC3;
        return v[7-j];
    endfunction

endmodule

// File: doc/askfsk_tx_core.md
Name: askfsk_tx_core

Overview:
Parametrised serial modulator for the ASK/FSK transmitter. It latches an MSG_W-bit message on a send request and shifts it out MSB-first, holding each bit for a programmable number of clocks. A phase-continuous accumulator generates a triangle carrier, which is shaped per bit by one of four modulation modes. The resulting sample drives a glitch-free PWM output. The block replaces the fixed-width divider/serializer/DDS/PWM chain with one configurable core that reports its status.

Parameters:
MSG_W, 8, message width in bits (minimum 2)
PHASE_W, 16, phase accumulator and frequency-word width
AMP_W, 9, sample width and PWM resolution (AMP_W <= PHASE_W-1)
BAUD_W, 16, width of the bit-period divider

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low
send  in  1  level request; sampled only in IDLE
msg  in  MSG_W  message, latched when send is accepted
mode  in  2  00 OOK, 01 FSK, 10 ASK (half amplitude for 0), 11 unmodulated carrier
baud_div  in  BAUD_W  clocks per bit minus 1, latched when send is accepted
fword_one  in  PHASE_W  phase increment for a 1 bit, and the carrier in modes 00/10/11
fword_zero  in  PHASE_W  phase increment for a 0 bit (mode 01 only)
busy  out  1  frame in progress
done  out  1  one-cycle pulse at end of frame
ser_bit  out  1  current transmitted bit
sample  out  AMP_W  registered modulated sample
pwm_out  out  1  PWM of sample

Behaviour:
- Reset (rst low, async): state IDLE; busy, done, ser_bit, sample, pwm_out, phase, PWM counter, duty, shift register and bit counters all 0.
- FSM IDLE -> DATA:
  - Edge with send=1 in IDLE: latch msg and baud_div; phase <= 0; baud counter <= 0; bit index <= MSG_W-1.
  - From that edge: busy=1 and ser_bit=msg[MSG_W-1].
- DATA bit timing:
  - Each bit lasts baud_div+1 clocks; the baud counter counts 0..baud_div.
  - At the wrap the next bit is presented (MSB-first).
  - baud_div=0 gives 1 clock per bit.
- DATA -> IDLE:
  - At the wrap of bit 0, return to IDLE; busy=0, done=1 for exactly that one cycle, ser_bit=0.
  - A frame occupies exactly MSG_W*(baud_div+1) busy cycles.
- send is ignored while busy. If send is held high, the next frame starts on the edge after done, so frames are separated by exactly one IDLE cycle.
- Only msg and baud_div are latched. mode, fword_one and fword_zero are live and take effect on the next edge.
- Phase accumulator:
  - While busy, phase <= phase + inc (mod 2^PHASE_W) each clock.
  - inc = fword_zero if mode=01 and ser_bit=0; otherwise inc = fword_one.
  - Phase is never cleared at bit boundaries (continuous phase). It is held in IDLE and cleared on frame start.
- Triangle:
  - t = phase[PHASE_W-2 -: AMP_W].
  - tri = phase[PHASE_W-1] ? ~t : t.
- Sample is registered one clock after phase, from current mode/ser_bit:
  - mode 00: ser_bit ? tri : 0
  - mode 01: tri
  - mode 10: ser_bit ? tri : tri>>1
  - mode 11: tri
  - Not busy: sample <= 0.
- PWM:
  - Free-running AMP_W-bit counter; period 2^AMP_W clocks.
  - duty <= sample only when counter = all-ones.
  - pwm_out <= (counter < duty), registered.
  - Duty D gives exactly D high clocks per period; duty 0 gives constant low.
- Reset asserted mid-frame aborts immediately with no done pulse. After release the block is in IDLE.

Test Plan:
1. Reset: hold rst=0 while toggling send and msg -> all outputs 0; release with send=0 -> still 0, busy=0.
2. FSK framing: MSG_W=8, msg=8'hA5, baud_div=3, mode=01 -> ser_bit sequence 1,0,1,0,0,1,0,1, each held 4 clocks; busy high 32 clocks; done single pulse on the cycle busy falls; final phase = 16*fword_one + 16*fword_zero mod 2^16.
3. Triangle values: PHASE_W=16, AMP_W=9, fword_one=16'h4000, msg=8'hFF, mode=01 -> sample sequence (one clock after phase) 256, 511, 255, 0, repeating.
4. OOK and ASK: msg=8'h0F, baud_div=7, fword_one=16'h4000.
   - mode=00 -> sample 0 for the first 32 busy clocks.
   - mode=10 -> sample values halved (128, 255, 127, 0) in the first 32 clocks, full values in the last 32.
5. Handshake: pulse send mid-frame -> ignored, frame length unchanged. Hold send high across done -> second frame begins after exactly one IDLE cycle with the new msg latched.
6. PWM and abort: sample latched as 256 -> pwm_out high for 256 of 512 clocks, no mid-period duty change. Assert rst at bit 3 -> all outputs 0 asynchronously, no done pulse.
